// File: rtl/fetch_pkg.sv
// Shared encodings and reset constants for the instruction-fetch sequencer.
// Optional FETCH_PERF_EN build adds performance counters to fetch_sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BEQ = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_HOLD = 2'b01,
    S_ERR  = 2'b10
  } fetch_state_t;

  // Only a register-indirect target can be misaligned.
  function automatic logic target_misaligned(input logic [1:0] sel, input logic [31:0] target);
    return (sel == SEL_JR) && (target[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect-target computation for seq, beq, j/jal and jr.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  redir_sel,
  input  logic [31:0] redir_pc,
  input  logic        redir_zero,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_addr,
  input  logic [31:0] redir_reg,
  output logic [31:0] target
);

  logic [31:0] p4;
  logic [31:0] br_off;

  assign p4     = redir_pc + 32'd4;
  assign br_off = {{14{redir_imm[15]}}, redir_imm, 2'b00};

  always_comb begin
    target = p4;
    case (redir_sel)
      SEL_SEQ: target = p4;
      SEL_BEQ: target = redir_zero ? (p4 + br_off) : p4;
      SEL_JMP: target = {p4[31:28], redir_addr, 2'b00};
      SEL_JR:  target = redir_reg;
      default: target = p4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, runs the imem req/ack handshake and
// hands one instruction at a time to decode. FETCH_PERF_EN adds perf counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  output logic                    if_valid,
  output logic [31:0]             if_instr,
  output logic [31:0]             if_pc,
  input  logic                    id_ready,
  input  logic                    redir_valid,
  input  logic [1:0]              redir_sel,
  input  logic [31:0]             redir_pc,
  input  logic                    redir_zero,
  input  logic [15:0]             redir_imm,
  input  logic [25:0]             redir_addr,
  input  logic [31:0]             redir_reg,
  output logic                    fetch_err,
`ifdef FETCH_PERF_EN
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_squashed,
  output logic [31:0]             perf_stall,
`endif
  output fetch_pkg::fetch_state_t dbg_state
);
  import fetch_pkg::*;

  // Handshakes: imem_req/imem_addr hold until imem_ack; decode takes an
  // instruction on the cycle where if_valid && id_ready are both high.
  fetch_state_t state;
  logic         squash;
  logic [31:0]  pc;
  logic [31:0]  redir_target;
  logic [31:0]  sel_pc;
  logic         bad_target;

  next_pc_calc u_next_pc (
    .redir_sel  (redir_sel),
    .redir_pc   (redir_pc),
    .redir_zero (redir_zero),
    .redir_imm  (redir_imm),
    .redir_addr (redir_addr),
    .redir_reg  (redir_reg),
    .target     (redir_target)
  );

  assign bad_target = redir_valid && target_misaligned(redir_sel, redir_target);
  assign sel_pc     = redir_valid ? redir_target : pc;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      squash    <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (bad_target) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            if_valid  <= 1'b0;
            squash    <= 1'b0;
          end else if (!imem_req) begin
            // Request not yet launched: a redirect simply retargets it.
            pc        <= sel_pc;
            imem_addr <= sel_pc;
            imem_req  <= 1'b1;
          end else if (imem_ack) begin
            if (squash || redir_valid) begin
              pc        <= sel_pc;
              imem_addr <= sel_pc;
              squash    <= 1'b0;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + 32'd4;
              imem_req <= 1'b0;
              state    <= S_HOLD;
            end
          end else if (redir_valid) begin
            // Address must stay stable; pc holds the pending target meanwhile.
            pc     <= redir_target;
            squash <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bad_target) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
            if_valid  <= 1'b0;
          end else if (redir_valid) begin
            if_valid  <= 1'b0;
            pc        <= redir_target;
            imem_addr <= redir_target;
            imem_req  <= 1'b1;
            state     <= S_REQ;
          end else if (id_ready) begin
            if_valid  <= 1'b0;
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_ERR: begin
          imem_req  <= 1'b0;
          if_valid  <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: begin
          state     <= S_ERR;
          imem_req  <= 1'b0;
          if_valid  <= 1'b0;
          fetch_err <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic live_ack;
  assign live_ack = (state == S_REQ) && imem_req && imem_ack && !bad_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
      perf_stall    <= '0;
    end else begin
      if (live_ack && !squash && !redir_valid)
        perf_fetched <= perf_fetched + 32'd1;
      if ((live_ack && (squash || redir_valid)) ||
          ((state == S_HOLD) && redir_valid && !id_ready))
        perf_squashed <= perf_squashed + 32'd1;
      if (if_valid && !id_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
